// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, funct codes,
// ALUop values and the 3-bit ALU operation type.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_JR    = 6'b000110;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU with zero detect; unassigned operation codes yield 0.
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] res;

    always_comb begin
        res = '0;
        case (op_i)
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
            ALU_ADD: res = a_i + b_i;
            ALU_SUB: res = a_i - b_i;
            ALU_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: res = '0;
        endcase
    end

    assign result_o = res;
    assign zero_o   = (res == '0);

endmodule

// File: rtl/mips_ctrl_alu.sv
// ID-stage main controller, EX-stage ALU-control decode and ALU, with a
// registered copy of the zero flag.
module mips_ctrl_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opc,
    input  logic              eq,
    input  logic [1:0]        ex_alu_op,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              jal,
    output logic              jr,
    output logic              jmp,
    output logic              mem_to_reg,
    output logic              mem_read,
    output logic              mem_write,
    output logic              alu_src,
    output logic              pc_src,
    output logic              if_flush,
    output logic [1:0]        alu_op,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              zero_q
);

    alu_ctrl_t ctrl;
    logic      zero_d;

    // Reset forces a bubble on every controller output, alu_op included.
    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        jal        = 1'b0;
        jr         = 1'b0;
        jmp        = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        pc_src     = 1'b0;
        alu_op     = ALUOP_MEM;
        if (!rst) begin
            case (opc)
                OPC_RTYPE: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                end
                OPC_ADDI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OPC_SLTI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = ALUOP_SLTI;
                end
                OPC_LW: begin
                    alu_src    = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                OPC_SW: begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                OPC_BEQ: begin
                    alu_op = ALUOP_BR;
                    pc_src = eq;
                end
                OPC_BNE: begin
                    alu_op = ALUOP_BR;
                    pc_src = ~eq;
                end
                OPC_J: jmp = 1'b1;
                OPC_JAL: begin
                    jmp       = 1'b1;
                    jal       = 1'b1;
                    reg_write = 1'b1;
                end
                OPC_JR: jr = 1'b1;
                default: ;
            endcase
        end
    end

    assign if_flush = pc_src | jmp | jr;

    always_comb begin
        ctrl = ALU_ADD;
        case (ex_alu_op)
            ALUOP_MEM:  ctrl = ALU_ADD;
            ALUOP_BR:   ctrl = ALU_SUB;
            ALUOP_SLTI: ctrl = ALU_SLT;
            default: begin
                case (func)
                    FUNC_ADD: ctrl = ALU_ADD;
                    FUNC_SUB: ctrl = ALU_SUB;
                    FUNC_AND: ctrl = ALU_AND;
                    FUNC_OR:  ctrl = ALU_OR;
                    FUNC_SLT: ctrl = ALU_SLT;
                    default:  ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    assign alu_ctrl = ctrl;

    mips_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (alu_ctrl),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (zero)
    );

    assign zero_d = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_q <= 1'b0;
        else     zero_q <= zero_d;
    end

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor
// pops one entry per cycle and compares every output group.
module tb_mips_ctrl_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opc;
    logic        eq;
    logic [1:0]  ex_alu_op;
    logic [5:0]  func;
    logic [31:0] alu_a, alu_b;
    logic        reg_dst, reg_write, jal, jr, jmp, mem_to_reg, mem_read;
    logic        mem_write, alu_src, pc_src, if_flush;
    logic [1:0]  alu_op;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero, zero_q;

    always #5 clk = ~clk;

    mips_ctrl_alu #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .opc(opc), .eq(eq), .ex_alu_op(ex_alu_op),
        .func(func), .alu_a(alu_a), .alu_b(alu_b),
        .reg_dst(reg_dst), .reg_write(reg_write), .jal(jal), .jr(jr),
        .jmp(jmp), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .pc_src(pc_src),
        .if_flush(if_flush), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .zero(zero), .zero_q(zero_q)
    );

    typedef struct {
        logic [10:0] ctl;   // reg_dst,reg_write,jal,jr,jmp,m2r,mrd,mwr,asrc,pcsrc,flush
        logic [1:0]  aop;
        logic [2:0]  actl;
        logic [31:0] res;
        logic        z;
        logic        zq;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_rst  = 1'b1;
    logic prev_zero = 1'b0;

    // Controls described as the set of asserted signals per instruction.
    function automatic void ctl_model(input logic r, input logic [5:0] o,
                                      input logic e, output logic [10:0] c,
                                      output logic [1:0] ao);
        logic rd = 0, rw = 0, jl = 0, jrr = 0, jm = 0, m2r = 0, mr = 0;
        logic mw = 0, as = 0, ps = 0;
        ao = 2'd0;
        if (!r) begin
            if (o == 6'd0)       begin rd = 1; rw = 1; ao = 2'd2; end
            else if (o == 6'd8)  begin as = 1; rw = 1; end
            else if (o == 6'd10) begin as = 1; rw = 1; ao = 2'd3; end
            else if (o == 6'd35) begin as = 1; mr = 1; m2r = 1; rw = 1; end
            else if (o == 6'd43) begin as = 1; mw = 1; end
            else if (o == 6'd4)  begin ao = 2'd1; ps = e; end
            else if (o == 6'd5)  begin ao = 2'd1; ps = !e; end
            else if (o == 6'd2)  jm = 1;
            else if (o == 6'd3)  begin jm = 1; jl = 1; rw = 1; end
            else if (o == 6'd6)  jrr = 1;
        end
        c = {rd, rw, jl, jrr, jm, m2r, mr, mw, as, ps, ps | jm | jrr};
    endfunction

    // Operation chosen by name, then evaluated with plain arithmetic.
    function automatic void alu_model(input logic [1:0] xo, input logic [5:0] f,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [2:0] code, output logic [31:0] r);
        string kind;
        if (xo == 2'd0)      kind = "add";
        else if (xo == 2'd1) kind = "sub";
        else if (xo == 2'd3) kind = "slt";
        else if (f == 6'd32) kind = "add";
        else if (f == 6'd34) kind = "sub";
        else if (f == 6'd36) kind = "and";
        else if (f == 6'd37) kind = "or";
        else if (f == 6'd42) kind = "slt";
        else                 kind = "add";
        case (kind)
            "add": begin code = 3'd2; r = 32'(longint'(a) + longint'(b)); end
            "sub": begin code = 3'd6; r = 32'(longint'(a) - longint'(b)); end
            "and": begin code = 3'd0; r = a & b; end
            "or":  begin code = 3'd1; r = a | b; end
            default: begin
                code = 3'd7;
                r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            end
        endcase
    endfunction

    task automatic apply(input logic r, input logic [5:0] o, input logic e,
                         input logic [1:0] xo, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; opc = o; eq = e; ex_alu_op = xo; func = f; alu_a = a; alu_b = b;
        ctl_model(r, o, e, x.ctl, x.aop);
        alu_model(xo, f, a, b, x.actl, x.res);
        x.z    = (x.res == 32'd0);
        x.zq   = (r || prev_rst) ? 1'b0 : prev_zero;
        x.name = nm;
        prev_rst  = r;
        prev_zero = x.z;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "ctl", 32'({reg_dst, reg_write, jal, jr, jmp, mem_to_reg,
                mem_read, mem_write, alu_src, pc_src, if_flush}), 32'(e.ctl));
            chk(e.name, "alu_op", 32'(alu_op), 32'(e.aop));
            chk(e.name, "alu_ctrl", 32'(alu_ctrl), 32'(e.actl));
            chk(e.name, "result", alu_result, e.res);
            chk(e.name, "zero", 32'(zero), 32'(e.z));
            chk(e.name, "zero_q", 32'(zero_q), 32'(e.zq));
        end
    end

    logic [5:0] opcs  [12] = '{6'd0, 6'd8, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5,
                               6'd2, 6'd3, 6'd6, 6'd63, 6'd17};
    logic [5:0] funcs [7]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd39};

    initial begin
        rst = 1'b1; opc = '0; eq = 1'b0; ex_alu_op = '0; func = '0;
        alu_a = '0; alu_b = '0;
        apply(1, 6'd35, 0, 2'd0, 6'd0, 32'h0, 32'h0, "reset_lw");
        apply(0, 6'd35, 0, 2'd0, 6'd0, 32'h10, 32'h4, "lw");
        apply(0, 6'd4, 1, 2'd1, 6'd0, 32'h5, 32'h6, "beq_taken");
        apply(0, 6'd4, 0, 2'd1, 6'd0, 32'h5, 32'h6, "beq_not");
        apply(0, 6'd5, 0, 2'd1, 6'd0, 32'h5, 32'h6, "bne_taken");
        apply(0, 6'd3, 0, 2'd0, 6'd0, 32'h1, 32'h1, "jal");
        apply(0, 6'd6, 0, 2'd0, 6'd0, 32'h1, 32'h1, "jr");
        apply(0, 6'd63, 1, 2'd0, 6'd0, 32'h1, 32'h1, "nop_opc");
        apply(0, 6'd0, 0, 2'd2, 6'd32, 32'hC, 32'hA, "r_add");
        apply(0, 6'd0, 0, 2'd2, 6'd34, 32'hC, 32'hA, "r_sub");
        apply(0, 6'd0, 0, 2'd2, 6'd36, 32'hC, 32'hA, "r_and");
        apply(0, 6'd0, 0, 2'd2, 6'd37, 32'hC, 32'hA, "r_or");
        apply(0, 6'd0, 0, 2'd2, 6'd42, 32'hC, 32'hA, "r_slt");
        apply(0, 6'd10, 0, 2'd3, 6'd0, 32'hFFFFFFFF, 32'h1, "slt_neg");
        apply(0, 6'd10, 0, 2'd3, 6'd0, 32'h80000000, 32'h0, "slt_min");
        apply(0, 6'd8, 0, 2'd0, 6'd0, 32'h7FFFFFFF, 32'h1, "add_ovf");
        apply(0, 6'd43, 0, 2'd1, 6'd0, 32'h0, 32'h1, "sub_wrap");
        apply(0, 6'd4, 1, 2'd1, 6'd0, 32'h1234, 32'h1234, "zero_set");
        apply(0, 6'd4, 1, 2'd1, 6'd0, 32'h1234, 32'h1234, "zero_hold");
        apply(0, 6'd4, 0, 2'd1, 6'd0, 32'h1235, 32'h1234, "zero_clr");
        apply(0, 6'd4, 0, 2'd1, 6'd0, 32'h1235, 32'h1234, "zero_q_clr");
        apply(0, 6'd4, 1, 2'd1, 6'd0, 32'h7, 32'h7, "pre_rst");
        apply(1, 6'd0, 0, 2'd1, 6'd0, 32'h7, 32'h7, "rst_mid");
        apply(0, 6'd0, 0, 2'd2, 6'd39, 32'h3, 32'h4, "func_dflt");
        for (int unsigned i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            logic [5:0]  o, f;
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h80000000;
                2: b = 32'h7FFFFFFF;
                default: ;
            endcase
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 11)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 6)];
            apply(($urandom_range(0, 29) == 0), o, 1'($urandom), 2'($urandom), f,
                  a, b, "random");
        end
        for (int unsigned k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_alu.md
Name: mips_ctrl_alu

Overview:
- Combinational decode and execute core for the 5-stage MIPS pipeline.
- Main controller: decodes the ID-stage opcode plus the register-equality flag into datapath, memory, writeback and PC-steering controls.
- ALU-control decoder: maps the EX-stage ALUop and funct to a 3-bit ALU operation.
- ALU: 32-bit datapath producing result and zero flag.
- Sits between the ID stage (controller outputs feed the ID/EX control mux) and the EX stage (ALU).

Parameters:
- DATA_W, 32, ALU operand/result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- opc  in  6  ID-stage opcode, Inst[31:26].
- eq  in  1  ReadData1 == ReadData2 from the ID stage.
- ex_alu_op  in  2  ALUop carried in the ID/EX register.
- func  in  6  EX-stage funct field.
- alu_a  in  DATA_W  ALU operand A (after forwarding).
- alu_b  in  DATA_W  ALU operand B (after ALUSrc mux).
- reg_dst, reg_write, jal, jr, jmp, mem_to_reg, mem_read, mem_write, alu_src, pc_src, if_flush  out  1 each  ID-stage controls.
- alu_op  out  2  ID-stage ALUop.
- alu_ctrl  out  3  decoded ALU operation.
- alu_result  out  DATA_W  ALU result.
- zero  out  1  alu_result == 0, combinational.
- zero_q  out  1  registered zero.

Behaviour:
- All outputs except zero_q are combinational, zero latency.
- While rst=1, every controller output (including alu_op) is 0, i.e. a bubble. ALU and alu_ctrl are unaffected by rst.
- zero_q: async cleared to 0 on rst; otherwise loads zero on each rising clk.
- Opcode decode (bits listed are set to 1; all others 0):
  - 000000 R-type: reg_dst, reg_write, alu_op=10.
  - 001000 addi: alu_src, reg_write, alu_op=00.
  - 001010 slti: alu_src, reg_write, alu_op=11.
  - 100011 lw: alu_src, mem_read, mem_to_reg, reg_write, alu_op=00.
  - 101011 sw: alu_src, mem_write, alu_op=00.
  - 000100 beq: alu_op=01; pc_src=eq.
  - 000101 bne: alu_op=01; pc_src=~eq.
  - 000010 j: jmp.
  - 000011 jal: jmp, jal, reg_write.
  - 000110 jr: jr.
  - Any other opcode: all outputs 0 (NOP).
- if_flush = pc_src | jmp | jr.
- ALU control:
  - ex_alu_op 00 -> 010 (add).
  - ex_alu_op 01 -> 110 (sub).
  - ex_alu_op 11 -> 111 (slt).
  - ex_alu_op 10 decodes func: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other func -> 010.
- ALU operations:
  - 000 = A & B; 001 = A | B; 010 = A + B, wrapping, no overflow flag.
  - 110 = A - B, two's complement, wrapping.
  - 111 = signed compare; result is 1 if $signed(A) < $signed(B), else 0.
  - Any other code: result 0, so zero=1.
- Boundary cases:
  - 0x7FFFFFFF + 1 = 0x80000000.
  - 0 - 1 = 0xFFFFFFFF.
  - slt of 0x80000000 vs 0 = 1.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: OPC_RTYPE, OPC_ADDI, OPC_SLTI, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_J, OPC_JAL, OPC_JR.
  - Funct constants.
  - ALUop encodings.
  - ALU control typedef alu_ctrl_t, with AND/OR/ADD/SUB/SLT values.
- One natural sub-module: mips_alu (ALU plus zero detect). Controller and ALU-control decode stay in the top block.

Test Plan:
- Reset: rst=1 with opc=100011 -> all controls 0, zero_q=0. Release rst -> mem_read=mem_to_reg=reg_write=alu_src=1, alu_op=00.
- Branch: opc=000100, eq=1 -> pc_src=1, if_flush=1, alu_op=01. With eq=0 -> pc_src=0, if_flush=0. opc=000101 with eq=0 -> pc_src=1.
- Jumps: opc=000011 -> jmp=jal=reg_write=if_flush=1. opc=000110 -> jr=if_flush=1, reg_write=0. Unknown opc=111111 -> all 0.
- R-type ALU: ex_alu_op=10 with each func against A=0x0000000C, B=0x0000000A:
  - add -> 0x16; sub -> 0x2; and -> 0x8; or -> 0xE; slt -> 0.
- Signed compare and overflow:
  - ex_alu_op=11, A=0xFFFFFFFF, B=1 -> 1.
  - add 0x7FFFFFFF+1 -> 0x80000000, zero=0.
- Zero flag: ex_alu_op=01, A=B=0x1234 -> result 0, zero=1. zero_q=1 after the next clk edge, and returns to 0 the cycle after A changes.
